uart_word_tx: RTL

Serial transmitter that sends one 32-bit word as a burst of 8N1 UART bytes on a single `tx` line. It is the transmit end of the UART link whose receive end delivers `wb_flag`/`wb_data` bytes. The core loads a word with a one-cycle `start` strobe. The block then shifts the word out least-significant byte first and pulses `done` when the last stop bit completes.

---
 rtl/uart_word_tx.sv | 127 ++++++++++++
 1 files changed

// File: rtl/uart_word_tx.sv
// 8N1 serial transmitter: sends one 32-bit word as BYTES bytes, least-significant
// byte first, with no gap between bytes, and pulses done after the last stop bit.
module uart_word_tx #(
  parameter int BAUD_DIV = 16,
  parameter int BYTES    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] word,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state_out,
  output logic [1:0]  byte_index
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [1:0]    LAST_IDX  = 2'(BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_baud, w_baud_nx;
  logic [2:0]    r_bit, w_bit_nx;
  logic [31:0]   r_shift, w_shift_nx;
  logic [1:0]    r_idx, w_idx_nx;
  logic          r_tx, w_tx_nx;
  logic          r_busy, w_busy_nx;
  logic          r_done, w_done_nx;
  logic          w_bit_end;

  assign w_bit_end = (r_baud == BAUD_LAST);

  // Handshake: start is a request accepted only on an edge where the state is
  // IDLE; busy is the inverse "ready" and stays high until the final stop bit ends.
  always_comb begin
    w_state_nx = r_state;
    w_baud_nx  = r_baud + CW'(1);
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_idx_nx   = r_idx;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;
    w_tx_nx    = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_baud_nx = '0;
        if (start) begin
          w_shift_nx = word;
          w_idx_nx   = 2'd0;
          w_busy_nx  = 1'b1;
          w_state_nx = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_baud_nx  = '0;
          w_bit_nx   = 3'd0;
          w_state_nx = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_nx  = '0;
          w_shift_nx = {1'b0, r_shift[31:1]};
          w_bit_nx   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_nx = S_STOP;
        end
      end
      default: begin
        if (w_bit_end) begin
          w_baud_nx = '0;
          if (r_idx == LAST_IDX) begin
            w_state_nx = S_IDLE;
            w_busy_nx  = 1'b0;
            w_done_nx  = 1'b1;
          end else begin
            w_idx_nx   = r_idx + 2'd1;
            w_state_nx = S_START;
          end
        end
      end
    endcase
    // tx is registered from the next state so the line changes on the same edge as the state.
    case (w_state_nx)
      S_START: w_tx_nx = 1'b0;
      S_DATA:  w_tx_nx = w_shift_nx[0];
      default: w_tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_shift <= 32'd0;
      r_idx   <= 2'd0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_baud  <= w_baud_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
      r_idx   <= w_idx_nx;
      r_tx    <= w_tx_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
    end
  end

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign done       = r_done;
  assign state_out  = r_state;
  assign byte_index = r_idx;

endmodule
